// File: rtl/co2_i2c_pkg.sv
// co2_i2c_pkg: shared constants and types for the K-30 CO2 sensor I2C emulator.
//   DEF_I2C_ADDR       default 7-bit target address
//   DEF_STATUS_OK/BUSY status bytes returned with / without a valid sample
//   CMD0..CMD3         the read-RAM command the master writes before reading
//   state_t            3-bit FSM state encoding (exposed on dbg_state[2:0])
//   cmd_byte()         expected command byte by index
package co2_i2c_pkg;

  localparam logic [6:0] DEF_I2C_ADDR    = 7'h68;
  localparam logic [7:0] DEF_STATUS_OK   = 8'h21;
  localparam logic [7:0] DEF_STATUS_BUSY = 8'h20;

  localparam logic [7:0] CMD0 = 8'h22;
  localparam logic [7:0] CMD1 = 8'h00;
  localparam logic [7:0] CMD2 = 8'h08;
  localparam logic [7:0] CMD3 = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD0;
      2'd1:    b = CMD1;
      2'd2:    b = CMD2;
      default: b = CMD3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings the asynchronous SCL/SDA pad inputs into the clk_i
// domain and derives single-cycle bus event pulses.
//   clk_i, rst_n_i  system clock, asynchronous active-low reset
//   scl_i, sda_i    raw pad inputs
//   sda_s           synchronized SDA level
//   scl_rise/fall   one-clk pulses on synchronized SCL edges
//   start/stop      one-clk pulses for START (SDA 1->0) / STOP (SDA 0->1)
//                   while SCL is high in both the current and history stage
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Reset to the idle-bus level (both lines high) so release of reset
  // never looks like an edge or a START.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/co2_i2c_target.sv
// co2_i2c_target: I2C target emulating the K-30 CO2 sensor read-RAM
// transaction (write D0 22 00 08 2A, STOP, then read D1 x4).
//   clk_i        system clock (>=16x SCL)
//   rst_n_i      asynchronous active-low reset
//   scl_i/sda_i  asynchronous pad inputs
//   sda_oe_o     1 = pull SDA low (open drain)
//   co2_value_i  CO2 ppm value, captured when the command is armed
//   value_vld_i  qualifies co2_value_i; sampled together with it at the STOP
//                that arms the command (level-sampled, no ready/ack back)
//   armed_o      command accepted, response pending
//   dbg_state    {armed_o, state[2:0]}
module co2_i2c_target
  import co2_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = DEF_I2C_ADDR,
  parameter logic [7:0] STATUS_OK   = DEF_STATUS_OK,
  parameter logic [7:0] STATUS_BUSY = DEF_STATUS_BUSY
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] co2_value_i,
  input  logic        value_vld_i,
  output logic        armed_o,
  output logic [3:0]  dbg_state
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t     state;
  logic [3:0] bit_cnt;      // SCL rises seen in the current byte, 0..8
  logic [2:0] byte_idx;     // data byte index, saturates at 4
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] cmd [4];
  logic       cmd_match;    // last write had 4 bytes equal to the command
  logic       wr_ovf;       // last write carried more than 4 data bytes
  logic       armed;
  logic       sda_oe;
  logic [7:0] snap_status;
  logic [7:0] snap_h;
  logic [7:0] snap_l;

  // Response byte for the current byte_idx. When nothing is armed the
  // response degenerates to BUSY/0/0 with a checksum equal to BUSY.
  logic [7:0] st_v, h_v, l_v, chk, tx_next;
  always_comb begin
    st_v = armed ? snap_status : STATUS_BUSY;
    h_v  = armed ? snap_h : 8'h00;
    l_v  = armed ? snap_l : 8'h00;
    chk  = st_v + h_v + l_v;
    case (byte_idx)
      3'd0:    tx_next = st_v;
      3'd1:    tx_next = h_v;
      3'd2:    tx_next = l_v;
      3'd3:    tx_next = chk;
      default: tx_next = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      byte_idx    <= 3'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      cmd         <= '{default: 8'h00};
      cmd_match   <= 1'b0;
      wr_ovf      <= 1'b0;
      armed       <= 1'b0;
      sda_oe      <= 1'b0;
      snap_status <= 8'h00;
      snap_h      <= 8'h00;
      snap_l      <= 8'h00;
    end else if (stop) begin
      state  <= ST_IDLE;
      sda_oe <= 1'b0;
      if (cmd_match && !wr_ovf) begin
        armed       <= 1'b1;
        snap_status <= value_vld_i ? STATUS_OK : STATUS_BUSY;
        snap_h      <= value_vld_i ? co2_value_i[15:8] : 8'h00;
        snap_l      <= value_vld_i ? co2_value_i[7:0]  : 8'h00;
      end
      // A command arms at most once; a following read-only STOP must not re-arm.
      cmd_match <= 1'b0;
    end else if (start) begin
      // Repeated START keeps cmd_match so a write followed by Sr-read still
      // arms at the final STOP.
      state    <= ST_ADDR;
      bit_cnt  <= 4'd0;
      byte_idx <= 3'd0;
      sda_oe   <= 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_sh   <= {rx_sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (rx_sh[7:1] == I2C_ADDR) begin
              state  <= ST_ADDR_ACK;
              sda_oe <= 1'b1;
            end else begin
              state <= ST_WAIT_STOP;
            end
          end
        end

        // Entered on a fall, so the next fall ends the ACK clock.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rx_sh[0]) begin
              state  <= ST_RD_BYTE;
              tx_sh  <= tx_next;
              sda_oe <= ~tx_next[7];
            end else begin
              state  <= ST_WR_BYTE;
              sda_oe <= 1'b0;
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            rx_sh   <= {rx_sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            state   <= ST_WR_ACK;
            if (byte_idx == 3'd0) begin
              armed     <= 1'b0;
              wr_ovf    <= 1'b0;
              cmd_match <= 1'b0;
            end
            if (byte_idx < 3'd4) begin
              cmd[byte_idx[1:0]] <= rx_sh;
              sda_oe             <= 1'b1;
              if (byte_idx == 3'd3)
                cmd_match <= (cmd[0] == cmd_byte(2'd0)) && (cmd[1] == cmd_byte(2'd1)) &&
                             (cmd[2] == cmd_byte(2'd2)) && (rx_sh == cmd_byte(2'd3));
            end else begin
              wr_ovf <= 1'b1;
            end
            if (byte_idx != 3'd4) byte_idx <= byte_idx + 3'd1;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= ST_WR_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b0;
              state   <= ST_RD_ACK;
            end else begin
              tx_sh  <= {tx_sh[6:0], 1'b0};
              sda_oe <= ~tx_sh[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (byte_idx == 3'd3) armed <= 1'b0;
            if (byte_idx != 3'd4) byte_idx <= byte_idx + 3'd1;
            if (sda_s) state <= ST_WAIT_STOP;
          end else if (scl_fall) begin
            // Only reached after an ACK; byte_idx already points at the next byte.
            state  <= ST_RD_BYTE;
            tx_sh  <= tx_next;
            sda_oe <= ~tx_next[7];
          end
        end

        default: ;  // IDLE and WAIT_STOP only react to START/STOP
      endcase
    end
  end

  assign sda_oe_o  = sda_oe;
  assign armed_o   = armed;
  assign dbg_state = {armed, state};

endmodule

// File: tb/tb_co2_i2c_target.sv
// tb_co2_i2c_target: bit-banged I2C master driving co2_i2c_target through a
// table of bus operations, plus a hand-written reset-mid-read sequence.
module tb_co2_i2c_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] co2_value = 16'h0000;
  logic        value_vld = 1'b0;
  logic        armed;
  logic [3:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int oe_cnt  = 0;
  int oe_base = 0;

  assign sda_line = sda_m & ~sda_oe;

  co2_i2c_target dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .scl_i       (scl),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .co2_value_i (co2_value),
    .value_vld_i (value_vld),
    .armed_o     (armed),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Quarter SCL period: 8 clocks, giving SCL = clk/32.
  task automatic hq();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; hq();
    scl   = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl   = 1'b0; hq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hq();
    scl   = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    hq();
    scl   = 1'b1; hq(); hq();
    scl   = 1'b0; hq();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; hq();
    scl   = 1'b1; hq();
    b     = sda_line; hq();
    scl   = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  // ---------------- vector table ----------------
  localparam logic [2:0] OP_S = 3'd0;  // START / repeated START
  localparam logic [2:0] OP_P = 3'd1;  // STOP, checks FSM back in IDLE
  localparam logic [2:0] OP_W = 3'd2;  // write d, expect ack == e[0]
  localparam logic [2:0] OP_R = 3'd3;  // read with nack = d[0], expect data e
  localparam logic [2:0] OP_C = 3'd4;  // mark sda_oe activity counter
  localparam logic [2:0] OP_Q = 3'd5;  // expect no sda_oe activity since mark

  typedef struct packed {
    logic [2:0]  op;
    logic        vld;
    logic [15:0] val;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [1:0]  ea;   // [1]=check armed_o after the op, [0]=expected value
  } vec_t;

  vec_t        tv[$];
  logic        cur_vld;
  logic [15:0] cur_val;

  localparam logic [1:0] NA = 2'b00;
  localparam logic [1:0] A0 = 2'b10;
  localparam logic [1:0] A1 = 2'b11;

  task automatic add(input logic [2:0] op, input logic [7:0] d, input logic [7:0] e,
                     input logic [1:0] ea);
    vec_t v;
    v.op = op; v.vld = cur_vld; v.val = cur_val; v.d = d; v.e = e; v.ea = ea;
    tv.push_back(v);
  endtask

  task automatic add_cmd(input logic [7:0] addr, input logic [7:0] b2, input logic ack);
    add(OP_S, 8'h00, 8'h00, NA);
    add(OP_W, addr,  {7'd0, ack}, NA);
    add(OP_W, 8'h22, {7'd0, ack}, NA);
    add(OP_W, 8'h00, {7'd0, ack}, NA);
    add(OP_W, b2,    {7'd0, ack}, NA);
    add(OP_W, 8'h2A, {7'd0, ack}, NA);
  endtask

  // ---------------- test ----------------
  initial begin
    logic       ack;
    logic [7:0] rb;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    check("rst_armed",  {15'd0, armed},  16'd0);
    check("rst_dbg",    {12'd0, dbg_state}, 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of a read while SDA is being pulled low
    value_vld = 1'b1; co2_value = 16'h01C2;
    bus_start();
    write_byte(8'hD0, ack); check("t1_ack_addr", {15'd0, ack}, 16'd1);
    write_byte(8'h22, ack); check("t1_ack_b0",   {15'd0, ack}, 16'd1);
    write_byte(8'h00, ack);
    write_byte(8'h08, ack);
    write_byte(8'h2A, ack); check("t1_ack_b3",   {15'd0, ack}, 16'd1);
    bus_stop(); hq();
    check("t1_armed", {15'd0, armed}, 16'd1);
    bus_start();
    write_byte(8'hD1, ack); check("t1_ack_rd", {15'd0, ack}, 16'd1);
    check("t1_oe_driving", {15'd0, sda_oe}, 16'd1);
    check("t1_dbg_rd", {12'd0, dbg_state}, 16'h000D);
    rst_n = 1'b0;
    #1;
    check("t1_rst_oe",    {15'd0, sda_oe}, 16'd0);
    check("t1_rst_armed", {15'd0, armed},  16'd0);
    check("t1_rst_dbg",   {12'd0, dbg_state}, 16'd0);
    scl = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    hq();
    scl = 1'b0; hq();
    oe_base = oe_cnt;
    write_byte(8'hD0, ack); check("t1_idle_noack", {15'd0, ack}, 16'd0);
    check("t1_idle_dbg", {12'd0, dbg_state}, 16'd0);
    check("t1_idle_oe", 16'(oe_cnt - oe_base), 16'd0);
    scl = 1'b1; hq();

    // Arm and read 21 01 C2 E4; value changes after STOP must not leak in
    cur_vld = 1'b1; cur_val = 16'h01C2;
    add_cmd(8'hD0, 8'h08, 1'b1);
    add(OP_P, 8'h00, 8'h00, A1);
    cur_val = 16'h1234;
    add(OP_S, 8'h00, 8'h00, NA);
    add(OP_W, 8'hD1, 8'h01, NA);
    add(OP_R, 8'h00, 8'h21, A1);
    add(OP_R, 8'h00, 8'h01, A1);
    add(OP_R, 8'h00, 8'hC2, A1);
    add(OP_R, 8'h01, 8'hE4, A0);
    add(OP_P, 8'h00, 8'h00, A0);

    // Read with nothing armed, then a 5th byte
    add(OP_S, 8'h00, 8'h00, NA);
    add(OP_W, 8'hD1, 8'h01, NA);
    add(OP_R, 8'h00, 8'h20, NA);
    add(OP_R, 8'h00, 8'h00, NA);
    add(OP_R, 8'h00, 8'h00, NA);
    add(OP_R, 8'h00, 8'h20, NA);
    add(OP_R, 8'h01, 8'hFF, A0);
    add(OP_P, 8'h00, 8'h00, A0);

    // Address mismatch: never drives SDA
    add(OP_C, 8'h00, 8'h00, NA);
    add_cmd(8'hD2, 8'h08, 1'b0);
    add(OP_P, 8'h00, 8'h00, A0);
    add(OP_Q, 8'h00, 8'h00, NA);

    // Wrong command byte, then 5 data bytes
    add_cmd(8'hD0, 8'h09, 1'b1);
    add(OP_P, 8'h00, 8'h00, A0);
    add_cmd(8'hD0, 8'h08, 1'b1);
    add(OP_W, 8'h00, 8'h00, NA);
    add(OP_P, 8'h00, 8'h00, A0);

    // Write, Sr read (not yet armed), STOP arms; then checksum wrap
    cur_val = 16'hFFF0;
    add_cmd(8'hD0, 8'h08, 1'b1);
    add(OP_S, 8'h00, 8'h00, A0);
    add(OP_W, 8'hD1, 8'h01, A0);
    add(OP_R, 8'h01, 8'h20, A0);
    add(OP_P, 8'h00, 8'h00, A1);
    add(OP_S, 8'h00, 8'h00, NA);
    add(OP_W, 8'hD1, 8'h01, NA);
    add(OP_R, 8'h00, 8'h21, NA);
    add(OP_R, 8'h00, 8'hFF, NA);
    add(OP_R, 8'h00, 8'hF0, NA);
    add(OP_R, 8'h01, 8'h10, A0);
    add(OP_P, 8'h00, 8'h00, A0);

    // Armed without a valid value: BUSY / 0 / 0 / BUSY
    cur_vld = 1'b0; cur_val = 16'h5678;
    add_cmd(8'hD0, 8'h08, 1'b1);
    add(OP_P, 8'h00, 8'h00, A1);
    add(OP_S, 8'h00, 8'h00, NA);
    add(OP_W, 8'hD1, 8'h01, NA);
    add(OP_R, 8'h00, 8'h20, A1);
    add(OP_R, 8'h00, 8'h00, NA);
    add(OP_R, 8'h00, 8'h00, NA);
    add(OP_R, 8'h01, 8'h20, A0);
    add(OP_P, 8'h00, 8'h00, A0);

    foreach (tv[i]) begin
      value_vld = tv[i].vld;
      co2_value = tv[i].val;
      case (tv[i].op)
        OP_S: bus_start();
        OP_P: begin
          bus_stop(); hq();
          check($sformatf("v%0d_stop_idle", i), {13'd0, dbg_state[2:0]}, 16'd0);
        end
        OP_W: begin
          write_byte(tv[i].d, ack);
          check($sformatf("v%0d_wr_ack", i), {15'd0, ack}, {15'd0, tv[i].e[0]});
        end
        OP_R: begin
          read_byte(tv[i].d[0], rb);
          check($sformatf("v%0d_rd_data", i), {8'd0, rb}, {8'd0, tv[i].e});
        end
        OP_C: oe_base = oe_cnt;
        OP_Q: check($sformatf("v%0d_oe_quiet", i), 16'(oe_cnt - oe_base), 16'd0);
        default: ;
      endcase
      if (tv[i].ea[1])
        check($sformatf("v%0d_armed", i), {15'd0, armed}, {15'd0, tv[i].ea[0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
